// File: rtl/register_file_controller.sv
// Sequencer for the BitBlaster register file, ALU latches and shared bus.
// One instruction is captured per Exec rising edge and walked through steps T0..T3.
module register_file_controller #(
    parameter int unsigned IR_W = 10,
    parameter int unsigned RA_W = 2,
    parameter int unsigned OP_W = 4
) (
    input  logic            CLKb,
    input  logic            Clrn,
    input  logic            Exec,
    input  logic [IR_W-1:0] INST,
    input  logic [RA_W-1:0] PeekA,
    output logic            IRin,
    output logic            Extrn,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic [OP_W-1:0] ALUcont,
    output logic            ENW,
    output logic [RA_W-1:0] WRA,
    output logic            ENR0,
    output logic [RA_W-1:0] RDA0,
    output logic            ENR1,
    output logic [RA_W-1:0] RDA1,
    output logic            Done,
    output logic [1:0]      Tstep
);

    localparam int unsigned RX_LSB = OP_W;
    localparam int unsigned RY_LSB = OP_W + RA_W;
    localparam int unsigned USED_W = OP_W + 2 * RA_W;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    step_t           r_t;
    logic [IR_W-1:0] r_ir;
    logic            r_exec_q;

    logic            w_start;
    logic [OP_W-1:0] w_op;
    logic [RA_W-1:0] w_rx;
    logic [RA_W-1:0] w_ry;
    logic            w_is_load;
    logic            w_is_copy;
    logic            w_is_alu;
    logic            w_unused_ir;

    assign w_op        = r_ir[OP_W-1:0];
    assign w_rx        = r_ir[RX_LSB +: RA_W];
    assign w_ry        = r_ir[RY_LSB +: RA_W];
    assign w_is_load   = (w_op == OP_W'(0));
    assign w_is_copy   = (w_op == OP_W'(1));
    assign w_is_alu    = (w_op >= OP_W'(2)) && (w_op <= OP_W'(11));
    assign w_start     = (r_t == T0) && Exec && !r_exec_q;
    assign w_unused_ir = ^r_ir[IR_W-1:USED_W];

    // Step counter, instruction capture and Exec edge history (negedge domain)
    always_ff @(negedge CLKb or negedge Clrn) begin
        if (!Clrn) begin
            r_t      <= T0;
            r_ir     <= '0;
            r_exec_q <= 1'b0;
        end else begin
            r_exec_q <= Exec;
            case (r_t)
                T0: begin
                    if (w_start) begin
                        r_ir <= INST;
                        r_t  <= T1;
                    end
                end
                T1:      r_t <= w_is_alu ? T2 : T0;
                T2:      r_t <= T3;
                T3:      r_t <= T0;
                default: r_t <= T0;
            endcase
        end
    end

    // Control decode; everything is forced low while Clrn is asserted
    always_comb begin
        IRin    = 1'b0;
        Extrn   = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        ALUcont = '0;
        ENW     = 1'b0;
        WRA     = '0;
        ENR0    = 1'b0;
        RDA0    = '0;
        ENR1    = 1'b0;
        RDA1    = '0;
        Done    = 1'b0;
        Tstep   = 2'd0;
        if (Clrn) begin
            ENR1  = 1'b1;
            RDA1  = PeekA;
            Tstep = r_t;
            case (r_t)
                T0: IRin = w_start;
                T1: begin
                    if (w_is_load) begin
                        Extrn = 1'b1;
                        ENW   = 1'b1;
                        WRA   = w_rx;
                        Done  = 1'b1;
                    end else if (w_is_copy) begin
                        ENR0 = 1'b1;
                        RDA0 = w_ry;
                        ENW  = 1'b1;
                        WRA  = w_rx;
                        Done = 1'b1;
                    end else if (w_is_alu) begin
                        ENR0 = 1'b1;
                        RDA0 = w_rx;
                        Ain  = 1'b1;
                    end else begin
                        Done = 1'b1;
                    end
                end
                T2: begin
                    ENR0    = 1'b1;
                    RDA0    = w_ry;
                    Gin     = 1'b1;
                    ALUcont = w_op;
                end
                T3: begin
                    Gout = 1'b1;
                    ENW  = 1'b1;
                    WRA  = w_rx;
                    Done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_controller.sv
// Bench for register_file_controller: directed scenarios plus random traffic
// compared against a per-instruction expected-step queue.
module tb_register_file_controller;

    logic       CLKb;
    logic       Clrn;
    logic       Exec;
    logic [9:0] INST;
    logic [1:0] PeekA;
    logic       IRin, Extrn, Ain, Gin, Gout, ENW, ENR0, ENR1, Done;
    logic [3:0] ALUcont;
    logic [1:0] WRA, RDA0, RDA1, Tstep;

    register_file_controller dut (
        .CLKb(CLKb), .Clrn(Clrn), .Exec(Exec), .INST(INST), .PeekA(PeekA),
        .IRin(IRin), .Extrn(Extrn), .Ain(Ain), .Gin(Gin), .Gout(Gout),
        .ALUcont(ALUcont), .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .RDA0(RDA0),
        .ENR1(ENR1), .RDA1(RDA1), .Done(Done), .Tstep(Tstep)
    );

    initial CLKb = 1'b1;
    always #5 CLKb = ~CLKb;

    // Layout: IRin Extrn Ain Gin Gout ALUcont[4] ENW WRA[2] ENR0 RDA0[2] ENR1 RDA1[2] Done Tstep[2]
    logic [20:0] obs;
    assign obs = {IRin, Extrn, Ain, Gin, Gout, ALUcont, ENW, WRA, ENR0, RDA0,
                  ENR1, RDA1, Done, Tstep};

    int n_checks = 0;
    int n_fail   = 0;
    int irin_cnt = 0;

    logic [20:0] exp_q[$];
    bit          prev_exec = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [20:0] mk(input bit extrn, input bit ain, input bit gin,
                                       input bit gout, input logic [3:0] alu, input bit enw,
                                       input logic [1:0] wra, input bit enr0,
                                       input logic [1:0] rda0, input bit done,
                                       input logic [1:0] t);
        return {1'b0, extrn, ain, gin, gout, alu, enw, wra, enr0, rda0, 1'b0, 2'b00, done, t};
    endfunction

    // Expected bus/control activity for each step after the capture edge
    task automatic push_steps(input logic [9:0] inst);
        logic [3:0] op;
        logic [1:0] rx, ry;
        op = inst[3:0];
        rx = inst[5:4];
        ry = inst[7:6];
        if (op == 4'd0) begin
            exp_q.push_back(mk(1, 0, 0, 0, 4'd0, 1, rx, 0, 2'd0, 1, 2'd1));
        end else if (op == 4'd1) begin
            exp_q.push_back(mk(0, 0, 0, 0, 4'd0, 1, rx, 1, ry, 1, 2'd1));
        end else if (op <= 4'd11) begin
            exp_q.push_back(mk(0, 1, 0, 0, 4'd0, 0, 2'd0, 1, rx, 0, 2'd1));
            exp_q.push_back(mk(0, 0, 1, 0, op, 0, 2'd0, 1, ry, 0, 2'd2));
            exp_q.push_back(mk(0, 0, 0, 1, 4'd0, 1, rx, 0, 2'd0, 1, 2'd3));
        end else begin
            exp_q.push_back(mk(0, 0, 0, 0, 4'd0, 0, 2'd0, 0, 2'd0, 1, 2'd1));
        end
    endtask

    task automatic run_cycle(input string tag, input logic exec, input logic [9:0] inst,
                             input logic [1:0] peek);
        logic [20:0] exp;
        bit          start;
        @(posedge CLKb);
        #1;
        Exec  = exec;
        INST  = inst;
        PeekA = peek;
        #1;
        start = (exp_q.size() == 0) && exec && !prev_exec;
        if (exp_q.size() == 0) exp = {start, 20'b0};
        else                   exp = exp_q[0];
        exp[5]   = 1'b1;
        exp[4:3] = peek;
        check_eq(tag, 32'(obs), 32'(exp));
        check_eq("single_bus_driver", 32'($countones({Extrn, ENR0, Gout}) <= 1), 32'd1);
        if (IRin) irin_cnt++;
        @(negedge CLKb);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        else if (start)        push_steps(inst);
        prev_exec = exec;
    endtask

    task automatic do_reset(input string tag);
        @(posedge CLKb);
        #1;
        Clrn = 1'b0;
        #1;
        check_eq(tag, 32'(obs), 32'd0);
        exp_q.delete();
        prev_exec = 1'b0;
        @(negedge CLKb);
        #1;
        Clrn = 1'b1;
    endtask

    initial begin
        Clrn  = 1'b0;
        Exec  = 1'b1;
        INST  = 10'h010;
        PeekA = 2'd2;
        #2;
        check_eq("reset_outputs", 32'(obs), 32'd0);
        @(negedge CLKb);
        #1;
        Clrn = 1'b1;

        run_cycle("idle", 1'b0, 10'h010, 2'd0);
        // LOAD R1
        run_cycle("load_start", 1'b1, 10'h010, 2'd1);
        run_cycle("load_t1", 1'b1, 10'h010, 2'd2);
        run_cycle("load_t0", 1'b0, 10'h010, 2'd3);
        // COPY R1 <- R3
        run_cycle("copy_start", 1'b1, 10'h0D1, 2'd0);
        run_cycle("copy_t1", 1'b0, 10'h0D1, 2'd1);
        run_cycle("copy_t0", 1'b0, 10'h0D1, 2'd2);
        // ADD R2 <- R2 + R1
        run_cycle("add_start", 1'b1, 10'h062, 2'd3);
        run_cycle("add_t1", 1'b0, 10'h062, 2'd0);
        run_cycle("add_t2", 1'b1, 10'h062, 2'd1);
        run_cycle("add_t3", 1'b0, 10'h062, 2'd2);
        run_cycle("add_t0", 1'b0, 10'h062, 2'd3);

        // Exec held high with INST changing after capture
        irin_cnt = 0;
        for (int i = 0; i < 10; i++)
            run_cycle("exec_held", 1'b1, (i < 1) ? 10'h010 : 10'h033, 2'(i));
        check_eq("irin_pulses", 32'(irin_cnt), 32'd1);
        run_cycle("exec_release", 1'b0, 10'h033, 2'd0);

        // Reset during T2 of SUB R1 <- R1 - R2
        run_cycle("sub_start", 1'b1, 10'h093, 2'd0);
        run_cycle("sub_t1", 1'b1, 10'h093, 2'd1);
        do_reset("reset_mid_sub");
        check_eq("state_after_reset", 32'(Tstep), 32'd0);
        run_cycle("post_reset_idle", 1'b0, 10'h020, 2'd1);
        run_cycle("post_reset_load", 1'b1, 10'h020, 2'd2);
        run_cycle("post_reset_t1", 1'b0, 10'h020, 2'd3);
        run_cycle("post_reset_t0", 1'b0, 10'h020, 2'd0);

        // NOP with peek sweep
        run_cycle("nop_start", 1'b1, 10'h00F, 2'd0);
        for (int p = 1; p < 4; p++)
            run_cycle("nop_peek", 1'b0, 10'h00F, 2'(p));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic e;
            if ($urandom_range(0, 79) == 0) begin
                do_reset("rand_reset");
            end else begin
                e = ($urandom_range(0, 2) == 0) ? ~Exec : Exec;
                run_cycle("random", e, 10'($urandom), 2'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_controller.md
Name: register_file_controller

Overview:
- Multi-step control unit that sequences the 4x10-bit register file, ALU operand/result latches and shared 10-bit bus for the BitBlaster processor.
- Captures an instruction on an execute request.
- Walks timesteps T0..T3 driving write/read enables and addresses so exactly one source drives the bus per step.
- Also drives the register file's second read port as a free-running peek port.

Parameters:
- IR_W, 10, instruction width.
- RA_W, 2, register address width (4 registers).
- OP_W, 4, opcode / ALU control width.

Ports:
- CLKb  in  1  clock; all state changes on the negative edge (same active edge as the register file).
- Clrn  in  1  asynchronous active-low reset.
- Exec  in  1  debounced execute request (level); only a 0->1 transition starts an instruction.
- INST  in  IR_W  instruction word: [3:0] opcode, [5:4] Rx (destination/first operand), [7:6] Ry (source), [9:8] ignored.
- PeekA  in  RA_W  register to show on peek port.
- IRin  out  1  instruction register load strobe (status).
- Extrn  out  1  external data drives the bus.
- Ain  out  1  ALU A latch loads the bus.
- Gin  out  1  ALU G result latch loads.
- Gout  out  1  G latch drives the bus.
- ALUcont  out  OP_W  ALU operation (equals opcode).
- ENW  out  1  register file write enable.
- WRA  out  RA_W  write address.
- ENR0  out  1  register file bus read enable.
- RDA0  out  RA_W  bus read address.
- ENR1  out  1  peek read enable.
- RDA1  out  RA_W  peek address.
- Done  out  1  final step of current instruction.
- Tstep  out  2  current timestep (0..3), for display.

Behaviour:
- State
  - 2-bit step counter T.
  - IR (IR_W bits).
  - ExecQ (Exec sampled on the previous edge).
  - All update on negedge CLKb.
  - Clrn=0 asynchronously forces T=0, IR=0, ExecQ=0.
- Outputs are combinational decode of T, IR, Exec, ExecQ, PeekA.
- Reset values (Clrn=0): every control output 0, ALUcont=0, WRA=RDA0=RDA1=0, ENR1=0, Tstep=0.
- Start condition: start = (T==0) & Exec & ~ExecQ.
- T0 (idle)
  - IRin=start; on that edge IR<=INST and T<=1.
  - Otherwise stay in T0 and hold IR.
  - Holding Exec high never re-triggers.
- Opcode classes (all following steps decode from IR, not INST):
  - 0000 LOAD: T1 Extrn=1, ENW=1, WRA=Rx, Done=1; then T0.
  - 0001 COPY: T1 ENR0=1, RDA0=Ry, ENW=1, WRA=Rx, Done=1; then T0.
  - 0010-1011 ALU (ADD, SUB, INV, FLP, AND, OR, XOR, LSL, LSR, ASR):
    - T1: ENR0=1, RDA0=Rx, Ain=1.
    - T2: ENR0=1, RDA0=Ry, Gin=1, ALUcont=opcode.
    - T3: Gout=1, ENW=1, WRA=Rx, Done=1; then T0.
  - 1100-1111 reserved NOP: T1 Done=1 only, no write; then T0.
- Latency: LOAD/COPY/NOP complete 2 active edges after start edge; ALU 4 edges. T3 reached only by ALU ops.
- Invariants
  - At most one of {Extrn, ENR0, Gout} high in any state.
  - ENW=0 in T0 and in every non-final step.
  - ALUcont=0 except in T2.
  - INST changes after capture have no effect.
- Peek port: ENR1=1 and RDA1=PeekA whenever Clrn=1, in all steps, independent of instruction flow.
- Rx==Ry is legal (e.g. ADD R1,R1 doubles R1).
- Exec rising during T1..T3 is ignored, but ExecQ still tracks Exec, so a request held across completion does not start a new instruction.
- Reset mid-instruction: outputs drop immediately (asynchronously), no write occurs, IR cleared; a subsequent Exec edge starts cleanly.

Test Plan:
- Reset then LOAD: Clrn 0->1, Exec edge with INST=0x010 (LOAD R1).
  - -> T1: Extrn=1, ENW=1, WRA=1, Done=1.
  - -> next edge: T0, all controls 0.
- COPY: INST=0x0D1 (COPY R1<-R3).
  - -> T1: ENR0=1, RDA0=3, ENW=1, WRA=1, Done=1.
  - -> Extrn/Gout/Ain=0.
- ADD: INST=0x062 (R2<-R2+R1).
  - -> T1: Ain=1, RDA0=2.
  - -> T2: Gin=1, RDA0=1, ALUcont=2.
  - -> T3: Gout=1, ENW=1, WRA=2, Done=1.
  - -> T0 after exactly 4 edges.
- Exec held high 10 cycles with INST=LOAD, INST changed to 0x033 mid-sequence.
  - -> exactly one instruction executes, using the captured IR; IRin pulses once.
- Clrn asserted during T2 of SUB.
  - -> ENW never asserted; T=0, IR=0 immediately; next Exec edge runs LOAD normally.
- NOP 0x00F and peek sweep PeekA=0..3 in all steps.
  - -> NOP: Done in T1, ENW=0.
  - -> ENR1=1, RDA1 follows PeekA every cycle.
